// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder_if
//  Brief    : Field-bundle handshake plus instruction-memory write port of the
//             instruction encoder, with status outputs.
//             master = bundle source / memory side, slave = the encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface instr_encoder_if #(
   parameter int ADDR_WIDTH = 8
);
   // bundle side
   logic                  start;
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            fmt;
   logic [6:0]            opcode;
   logic [4:0]            rd;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [31:0]           imm;
   // memory write port
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  mem_ready;
   // status
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  err;

   modport master (
      output start, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
             mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
   );

   modport slave (
      input  start, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
             mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
   );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Brief    : Sequential RV32I instruction packer. Scatters a 32-bit immediate
//             and register/function fields into an instruction word according
//             to the immSrc format code and writes the words to consecutive
//             instruction-memory addresses through a one-entry pending stage.
//  Macro    : IMM_RANGE_CHECK_EN - when defined, bundles whose immediate does
//             not fit the selected format are rejected (err set, no write).
//  Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
   parameter int ADDR_WIDTH = 8
) (
   input wire            clk,
   input wire            rst,
   instr_encoder_if.slave bus
);
   // DEPTH and DEPTH-1 expressed at the width of the write counter
   localparam logic [ADDR_WIDTH:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] c_last  = {1'b0, {ADDR_WIDTH{1'b1}}};

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,   // no pending write
      S_WRITE = 1'b1    // pending write presented on the memory port
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [ADDR_WIDTH:0] count_q, count_d;
   logic                err_q,   err_d;

   logic [31:0]         w_word;
   logic                w_fmt_ok;
   logic                w_range_ok;
   logic                w_legal;
   logic                w_in_ready;
   logic                w_accept;
   logic                w_complete;

   // Scatter the fields into the instruction word for the selected format
   always_comb begin
      w_word   = 32'h0;
      w_fmt_ok = 1'b1;
      case (bus.fmt)
         3'b000:  w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         3'b001:  w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.imm[4:0], bus.opcode};
         3'b010:  w_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.imm[4:1], bus.imm[11], bus.opcode};
         3'b011:  w_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                            bus.rd, bus.opcode};
         3'b100:  w_word = {bus.imm[31:12], bus.rd, bus.opcode};
         3'b101:  w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         default: w_fmt_ok = 1'b0;
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // Immediate must be representable by the bits the format keeps
   always_comb begin
      w_range_ok = 1'b1;
      case (bus.fmt)
         3'b000, 3'b001: w_range_ok = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
         3'b010:         w_range_ok = ((&bus.imm[31:12]) | ~(|bus.imm[31:12])) & ~bus.imm[0];
         3'b011:         w_range_ok = ((&bus.imm[31:20]) | ~(|bus.imm[31:20])) & ~bus.imm[0];
         3'b100:         w_range_ok = ~(|bus.imm[11:0]);
         default:        w_range_ok = 1'b1;
      endcase
   end
`else
   assign w_range_ok = 1'b1;
`endif

   assign w_legal = w_fmt_ok & w_range_ok;

   // Ready when a slot will be free this cycle and the memory is not yet full;
   // deliberately independent of in_valid
   always_comb begin
      w_in_ready = 1'b0;
      if (!rst && !bus.start) begin
         if (state_q == S_IDLE) w_in_ready = (count_q < c_depth);
         else                   w_in_ready = bus.mem_ready && (count_q < c_last);
      end
   end

   assign w_complete = (state_q == S_WRITE) && bus.mem_ready;
   assign w_accept   = bus.in_valid && w_in_ready;

   // Next-state: start clears everything; otherwise retire and/or load the pending entry
   always_comb begin
      state_d = state_q;
      wdata_d = wdata_q;
      count_d = count_q;
      err_d   = err_q;
      if (bus.start) begin
         state_d = S_IDLE;
         wdata_d = 32'h0;
         count_d = '0;
         err_d   = 1'b0;
      end else begin
         if (w_complete) begin
            count_d = count_q + 1'b1;
            state_d = S_IDLE;
         end
         if (w_accept) begin
            if (w_legal) begin
               state_d = S_WRITE;
               wdata_d = w_word;
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wdata_q <= 32'h0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.mem_we    = (state_q == S_WRITE);
   assign bus.mem_addr  = count_q[ADDR_WIDTH-1:0];
   assign bus.mem_wdata = wdata_q;
   assign bus.count     = count_q;
   assign bus.full      = (count_q == c_depth);
   assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Brief    : Scoreboard bench for instr_encoder. The stimulus thread keeps a
//             transaction-level model (write counter, pending flag, sticky
//             error, queue of expected words); a monitor thread compares the
//             DUT's outputs and memory writes against it every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder;
   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   word;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model state
   int   m_count = 0;
   bit   m_pend  = 1'b0;
   bit   m_err   = 1'b0;
   exp_t q[$];
   bit   armed    = 1'b0;
   bit   last_acc = 1'b0;
   bit   d_use    = 1'b0;
   logic [31:0] d_word = 32'h0;

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();
   instr_encoder #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction word straight from the format table
   function automatic logic [31:0] ref_word();
      logic [31:0] i;
      i = bus.imm;
      case (bus.fmt)
         3'd0: return {i[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         3'd1: return {i[11:5], bus.rs2, bus.rs1, bus.funct3, i[4:0], bus.opcode};
         3'd2: return {i[12], i[10:5], bus.rs2, bus.rs1, bus.funct3, i[4:1], i[11], bus.opcode};
         3'd3: return {i[20], i[10:1], i[11], i[19:12], bus.rd, bus.opcode};
         3'd4: return {i[31:12], bus.rd, bus.opcode};
         default: return {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      endcase
   endfunction

   // Legality as numeric ranges of the signed immediate
   function automatic bit ref_legal();
      int v;
      v = $signed(bus.imm);
      if (bus.fmt > 3'd5) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      case (bus.fmt)
         3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
         3'd2:       return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
         3'd3:       return (v >= -(1 << 20)) && (v < (1 << 20)) && (v % 2 == 0);
         3'd4:       return (v % 4096) == 0;
         default:    return 1'b1;
      endcase
`else
      return 1'b1;
`endif
   endfunction

   function automatic bit ref_ready();
      if (rst || bus.start) return 1'b0;
      if (!m_pend) return m_count < DEPTH;
      return bus.mem_ready && (m_count + 1 < DEPTH);
   endfunction

   // Advance one clock and update the model with the inputs seen at that edge
   task automatic step();
      bit   rdy, cmp, acc;
      exp_t e;
      @(posedge clk);
      rdy = ref_ready();
      cmp = m_pend && bus.mem_ready;
      acc = bus.in_valid && rdy;
      last_acc = acc;
      if (rst || bus.start) begin
         m_count = 0;
         m_pend  = 1'b0;
         m_err   = 1'b0;
         q.delete();
      end else begin
         if (cmp) begin
            m_count++;
            m_pend = 1'b0;
         end
         if (acc) begin
            if (ref_legal()) begin
               e.addr = m_count[AW-1:0];
               e.word = d_use ? d_word : ref_word();
               q.push_back(e);
               m_pend = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [31:0] imm, input logic [31:0] w);
      bus.fmt = f; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
      bus.funct3 = f3; bus.funct7 = 7'h0; bus.imm = imm;
      d_use = 1'b1; d_word = w;
   endtask

   // Hold a bundle valid until the model accepts it (bounded)
   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm, input logic [31:0] w);
      int n;
      set_fields(f, op, rd, rs1, rs2, f3, imm, w);
      bus.in_valid = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!last_acc && n < 20);
      n_cmp++;
      if (!last_acc) begin
         n_bad++;
         $display("FAIL send_timeout: accepted=0, required=1 within 20 cycles at %0t", $time);
      end
      bus.in_valid = 1'b0;
      d_use = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   // Monitor: compare status and memory writes against the model each cycle
   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            check("in_ready", 32'(bus.in_ready), 32'(ref_ready()));
            check("mem_we",   32'(bus.mem_we),   32'(m_pend));
            check("count",    32'(bus.count),    32'(m_count));
            check("full",     32'(bus.full),     32'(m_count == DEPTH));
            check("err",      32'(bus.err),      32'(m_err));
            if (bus.mem_we) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, required no write at %0t",
                           bus.mem_addr, bus.mem_wdata, $time);
               end else begin
                  check("mem_addr",  32'(bus.mem_addr), 32'(q[0].addr));
                  check("mem_wdata", bus.mem_wdata,     q[0].word);
                  if (bus.mem_ready) void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
      bus.fmt = 3'd0; bus.opcode = 7'h0; bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
      bus.funct3 = 3'd0; bus.funct7 = 7'h0; bus.imm = 32'h0;
      rst = 1'b1;
      step();
      armed = 1'b1;
      step();
      rst = 1'b0;
      check("rst_wdata", bus.mem_wdata, 32'h0);
      check("rst_addr",  32'(bus.mem_addr), 32'h0);

      // I-type, single write
      bus.mem_ready = 1'b1;
      send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093);
      step();
      check("t1_count", 32'(bus.count), 32'd1);

      // S then B back to back
      pulse_start();
      send(3'd1, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8, 32'h0021A423);
      send(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 32'hFE000EE3);
      step(); step();
      check("t2_count", 32'(bus.count), 32'd2);

      // J held by 3 stall cycles, U queued behind it
      pulse_start();
      send(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 32'h001000EF);
      bus.mem_ready = 1'b0;
      set_fields(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7);
      bus.in_valid = 1'b1;
      repeat (3) step();
      bus.mem_ready = 1'b1;
      send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7);
      step(); step();

      // illegal format, then an I with an out-of-range immediate
      pulse_start();
      send(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 32'h0);
      send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h80000093);
      step(); step();
      check("t4_err", 32'(bus.err), 32'd1);

      // fill to DEPTH, extra bundle ignored, start recovers
      pulse_start();
      for (int i = 0; i < DEPTH; i++)
         send(3'd0, 7'b0010011, 5'(i), 5'd0, 5'd0, 3'd0, 32'(i),
              (32'(i) << 20) | (32'(i) << 7) | 32'h13);
      step(); step();
      check("full_count", 32'(bus.count), 32'(DEPTH));
      check("full_flag",  32'(bus.full), 32'd1);
      check("full_ready", 32'(bus.in_ready), 32'd0);
      set_fields(3'd0, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'd9, 32'h00900193);
      bus.in_valid = 1'b1;
      repeat (3) step();
      bus.in_valid = 1'b0;
      d_use = 1'b0;
      pulse_start();
      check("restart_count", 32'(bus.count), 32'd0);
      check("restart_full",  32'(bus.full), 32'd0);
      send(3'd0, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 32'd7, 32'h00700113);
      step(); step();

      // start abandons a stalled write
      pulse_start();
      bus.mem_ready = 1'b0;
      send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 32'h00100093);
      step();
      check("stall_we", 32'(bus.mem_we), 32'd1);
      pulse_start();
      check("abandon_we",    32'(bus.mem_we), 32'd0);
      check("abandon_count", 32'(bus.count), 32'd0);

      // randomized traffic
      d_use = 1'b0;
      for (int i = 0; i < 800; i++) begin
         bus.in_valid = ($urandom_range(0, 9) < 7);
         bus.fmt      = 3'($urandom_range(0, 7));
         bus.opcode   = 7'($urandom);
         bus.rd       = 5'($urandom);
         bus.rs1      = 5'($urandom);
         bus.rs2      = 5'($urandom);
         bus.funct3   = 3'($urandom);
         bus.funct7   = 7'($urandom);
         case ($urandom_range(0, 3))
            0:       bus.imm = $urandom;
            1:       bus.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       bus.imm = $urandom & 32'hFFFFF000;
            default: bus.imm = 32'($urandom_range(0, (1 << 21) - 1)) - 32'(1 << 20);
         endcase
         bus.mem_ready = ($urandom_range(0, 3) != 0);
         bus.start     = ($urandom_range(0, 29) == 0);
         rst           = ($urandom_range(0, 99) == 0);
         step();
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      rst          = 1'b0;
      bus.mem_ready = 1'b1;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
